// File: rtl/lrsr_seq_ctrl_if.sv
// rtl/lrsr_seq_ctrl_if.sv - command, load, unload and bit-stream handshakes of the shift-register sequencer
interface lrsr_seq_ctrl_if #(
  parameter int W  = 16,
  parameter int SW = 9
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [SW-1:0] cmd_shamt;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          bit_valid;
  logic          bit_out;
  logic          done;

  modport master (
    output cmd_valid, cmd_shamt, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, bit_valid, bit_out, done
  );

  modport slave (
    input  cmd_valid, cmd_shamt, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, bit_valid, bit_out, done
  );
endinterface

// File: rtl/lrsr_seq_ctrl.sv
// rtl/lrsr_seq_ctrl.sv - load / left-shift / unload sequencer for the 256-bit left/right shift register
module lrsr_seq_ctrl #(
  parameter int W      = 16,
  parameter int NWORDS = 16,
  parameter int SW     = 9
) (
  input  logic                clk,
  input  logic                clr,
  lrsr_seq_ctrl_if.slave      bus,
  output logic                sr_clr,
  output logic                sr_we,
  output logic                sr_sel_ls,
  output logic [W-1:0]        sr_regin,
  input  logic [W-1:0]        sr_regout,
  input  logic                sr_b256
);
  localparam int             WCW   = $clog2(NWORDS);
  localparam logic [SW-1:0]  SHMAX = SW'(NWORDS * W);
  localparam logic [WCW-1:0] WLAST = WCW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, UNLOAD} state_t;

  state_t         state, next;
  logic [WCW-1:0] wcnt;
  logic [SW-1:0]  bcnt;
  logic [SW-1:0]  shamt;
  logic           bit_valid_q;
  logic           done_q;
  logic           cmd_ready, in_ready, out_valid;

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      wcnt        <= '0;
      bcnt        <= '0;
      shamt       <= '0;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= next;
      // the shifted-out bit lands in sr_b256 one edge after each shift cycle
      bit_valid_q <= (state == SHIFT);
      done_q      <= (state == UNLOAD) && bus.out_ready && (wcnt == WLAST);
      case (state)
        IDLE: if (bus.cmd_valid) begin
          shamt <= (bus.cmd_shamt > SHMAX) ? SHMAX : bus.cmd_shamt;
          wcnt  <= '0;
        end
        LOAD: if (bus.in_valid) begin
          wcnt <= (wcnt == WLAST) ? '0 : wcnt + WCW'(1);
          if (wcnt == WLAST) bcnt <= '0;
        end
        SHIFT:  bcnt <= bcnt + SW'(1);
        UNLOAD: if (bus.out_ready) wcnt <= (wcnt == WLAST) ? '0 : wcnt + WCW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    next      = state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sr_we     = 1'b0;
    sr_sel_ls = 1'b0;
    sr_regin  = '0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) next = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          sr_we    = 1'b1;
          sr_regin = bus.in_data;
          if (wcnt == WLAST) next = (shamt == '0) ? UNLOAD : SHIFT;
        end
      end
      SHIFT: begin
        sr_we     = 1'b1;
        sr_sel_ls = 1'b1;
        if (bcnt == shamt - SW'(1)) next = UNLOAD;
      end
      UNLOAD: begin
        out_valid = 1'b1;
        // zeros shifted in at the top leave the register cleared after the last word
        if (bus.out_ready) begin
          sr_we = 1'b1;
          if (wcnt == WLAST) next = IDLE;
        end
      end
      default: next = IDLE;
    endcase
    if (clr) begin
      next      = IDLE;
      cmd_ready = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      sr_we     = 1'b0;
      sr_sel_ls = 1'b0;
      sr_regin  = '0;
    end
  end

  assign sr_clr        = clr | ((state == IDLE) & bus.cmd_valid);
  assign bus.cmd_ready = cmd_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = sr_regout;
  assign bus.bit_valid = bit_valid_q;
  assign bus.bit_out   = sr_b256;
  assign bus.done      = done_q;
endmodule
